vga_scanout: RTL

Display scan-out engine sitting directly downstream of the I/O memory's GPU read port. It generates 640x480 VGA timing, issues pixel addresses on `gpu_address`, consumes the 8-bit grayscale pixels returned on `gpu_out`, and drives aligned RGB/sync/blank outputs. It also owns `gpu_sel` (encrypted vs decrypted image), switching it only on frame boundaries so no frame mixes the two images.

---
 rtl/vga_pkg.sv | 50 +++++
 rtl/vga_scanout_if.sv | 29 ++
 rtl/vga_timing.sv | 77 +++++++
 rtl/vga_scanout.sv | 108 ++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared timing constants, image geometry and pipeline flag type for the VGA scan-out engine.
package vga_pkg;

  // 640x480 @ 60 Hz horizontal timing, in pixel clocks
  localparam int unsigned HVisible = 640;
  localparam int unsigned HFront   = 16;
  localparam int unsigned HSync    = 96;
  localparam int unsigned HBack    = 48;
  localparam int unsigned HTotal   = HVisible + HFront + HSync + HBack;

  // Vertical timing, in lines
  localparam int unsigned VVisible = 480;
  localparam int unsigned VFront   = 10;
  localparam int unsigned VSync    = 2;
  localparam int unsigned VBack    = 33;
  localparam int unsigned VTotal   = VVisible + VFront + VSync + VBack;

  // Image placement inside the visible area
  localparam int unsigned ImgW = 256;
  localparam int unsigned ImgH = 256;
  localparam int unsigned X0   = 192;
  localparam int unsigned Y0   = 112;

  localparam int unsigned MemLatency = 1;
  localparam int unsigned AddrW      = 32;
  localparam int unsigned PixW       = 8;

  // Per-pixel control flags carried down the delay line alongside the memory read
  typedef struct packed {
    logic frame_start;
    logic window;
    logic visible;
    logic vsync_n;
    logic hsync_n;
  } pix_flags_t;

  localparam pix_flags_t FlagsReset = '{
    frame_start: 1'b0,
    window:      1'b0,
    visible:     1'b0,
    vsync_n:     1'b1,
    hsync_n:     1'b1
  };

  // True when lo <= x < lo + len
  function automatic logic in_range(logic [31:0] x, int unsigned lo, int unsigned len);
    return (x >= lo) && (x < lo + len);
  endfunction

endpackage

// File: rtl/vga_scanout_if.sv
// Memory read port plus video pins of the scan-out engine.
interface vga_scanout_if;
  import vga_pkg::*;

  logic [AddrW-1:0] gpu_address;
  logic [PixW-1:0]  gpu_out;
  logic             gpu_sel;
  logic             sel_request;
  logic [PixW-1:0]  vga_r;
  logic [PixW-1:0]  vga_g;
  logic [PixW-1:0]  vga_b;
  logic             vga_hsync;
  logic             vga_vsync;
  logic             vga_blank_n;
  logic             frame_start;

  modport master (
    output gpu_address, gpu_sel, vga_r, vga_g, vga_b, vga_hsync, vga_vsync, vga_blank_n,
           frame_start,
    input  gpu_out, sel_request
  );

  modport slave (
    input  gpu_address, gpu_sel, vga_r, vga_g, vga_b, vga_hsync, vga_vsync, vga_blank_n,
           frame_start,
    output gpu_out, sel_request
  );

endinterface

// File: rtl/vga_timing.sv
// Horizontal/vertical raster counters and the stage-0 sync, visible and window flags.
module vga_timing
  import vga_pkg::*;
#(
  parameter int unsigned HVis      = HVisible,
  parameter int unsigned HFp       = HFront,
  parameter int unsigned HSw       = HSync,
  parameter int unsigned HBp       = HBack,
  parameter int unsigned VVis      = VVisible,
  parameter int unsigned VFp       = VFront,
  parameter int unsigned VSw       = VSync,
  parameter int unsigned VBp       = VBack,
  parameter int unsigned ImgWidth  = ImgW,
  parameter int unsigned ImgHeight = ImgH,
  parameter int unsigned ImgX0     = X0,
  parameter int unsigned ImgY0     = Y0
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] h_o,
  output logic        line_end_o,
  output logic        img_row_o,
  output logic        pre_img_row_o,
  output logic        frame_end_o,
  output pix_flags_t  flags_o
);

  localparam int unsigned HTot = HVis + HFp + HSw + HBp;
  localparam int unsigned VTot = VVis + VFp + VSw + VBp;
  localparam int unsigned HW   = $clog2(HTot);
  localparam int unsigned VW   = $clog2(VTot);
  // Line on whose last cycle the row base is cleared ahead of the first image line
  localparam int unsigned RowClrLine = (ImgY0 == 0) ? VTot - 1 : ImgY0 - 1;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [31:0]   v;

  assign h_o           = 32'(h_q);
  assign v             = 32'(v_q);
  assign line_end_o    = (h_o == HTot - 1);
  assign frame_end_o   = line_end_o && (v == VTot - 1);
  assign img_row_o     = in_range(v, ImgY0, ImgHeight);
  assign pre_img_row_o = (v == RowClrLine);

  // Counter advance: h wraps every line, v steps on the h wrap and wraps at frame end
  always_comb begin
    h_d = h_q + 1'b1;
    v_d = v_q;
    if (line_end_o) begin
      h_d = '0;
      v_d = frame_end_o ? '0 : v_q + 1'b1;
    end
  end

  // Raster position register
  always_ff @(posedge clk) begin
    if (rst) begin
      h_q <= '0;
      v_q <= '0;
    end else begin
      h_q <= h_d;
      v_q <= v_d;
    end
  end

  // Stage-0 flags decoded straight from the counters
  always_comb begin
    flags_o             = FlagsReset;
    flags_o.hsync_n     = !in_range(h_o, HVis + HFp, HSw);
    flags_o.vsync_n     = !in_range(v, VVis + VFp, VSw);
    flags_o.visible     = (h_o < HVis) && (v < VVis);
    flags_o.window      = in_range(h_o, ImgX0, ImgWidth) && img_row_o;
    flags_o.frame_start = (h_q == '0) && (v_q == '0);
  end

endmodule

// File: rtl/vga_scanout.sv
// Scan-out top: pixel address generation, flag delay line matched to memory latency,
// registered video pins and frame-synchronous image select.
module vga_scanout
  import vga_pkg::*;
#(
  parameter int unsigned HVis      = HVisible,
  parameter int unsigned HFp       = HFront,
  parameter int unsigned HSw       = HSync,
  parameter int unsigned HBp       = HBack,
  parameter int unsigned VVis      = VVisible,
  parameter int unsigned VFp       = VFront,
  parameter int unsigned VSw       = VSync,
  parameter int unsigned VBp       = VBack,
  parameter int unsigned ImgWidth  = ImgW,
  parameter int unsigned ImgHeight = ImgH,
  parameter int unsigned ImgX0     = X0,
  parameter int unsigned ImgY0     = Y0,
  parameter int unsigned MemLat    = MemLatency
) (
  input logic           clk,
  input logic           rst,
  vga_scanout_if.master bus
);

  // Flags wait one cycle for the address register plus MemLat for the read
  localparam int unsigned Depth = MemLat + 1;

  logic [31:0] h;
  logic        line_end, img_row, pre_img_row, frame_end;
  pix_flags_t  flags_s0;

  logic [AddrW-1:0]         row_base_q, row_base_d;
  logic [AddrW-1:0]         addr_q, addr_d;
  logic                     sel_q, sel_d;
  pix_flags_t [Depth-1:0]   dly_q, dly_d;
  pix_flags_t               out_q, out_d;
  logic [PixW-1:0]          pix_q, pix_d;

  vga_timing #(
    .HVis      (HVis),
    .HFp       (HFp),
    .HSw       (HSw),
    .HBp       (HBp),
    .VVis      (VVis),
    .VFp       (VFp),
    .VSw       (VSw),
    .VBp       (VBp),
    .ImgWidth  (ImgWidth),
    .ImgHeight (ImgHeight),
    .ImgX0     (ImgX0),
    .ImgY0     (ImgY0)
  ) u_timing (
    .clk           (clk),
    .rst           (rst),
    .h_o           (h),
    .line_end_o    (line_end),
    .img_row_o     (img_row),
    .pre_img_row_o (pre_img_row),
    .frame_end_o   (frame_end),
    .flags_o       (flags_s0)
  );

  // Next-state: row base stepping (no multiplier), address, select latch, delay line, pins
  always_comb begin
    row_base_d = row_base_q;
    if (line_end && pre_img_row) begin
      row_base_d = '0;
    end else if (line_end && img_row) begin
      row_base_d = row_base_q + ImgWidth;
    end
    addr_d = flags_s0.window ? row_base_q + (h - ImgX0) : '0;
    // Select only moves as the counters wrap to (0,0) so a frame never mixes images
    sel_d  = frame_end ? bus.sel_request : sel_q;
    dly_d  = {dly_q[Depth-2:0], flags_s0};
    out_d  = dly_q[Depth-1];
    pix_d  = dly_q[Depth-1].window ? bus.gpu_out : '0;
  end

  // Pipeline and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      row_base_q <= '0;
      addr_q     <= '0;
      sel_q      <= 1'b0;
      dly_q      <= {Depth{FlagsReset}};
      out_q      <= FlagsReset;
      pix_q      <= '0;
    end else begin
      row_base_q <= row_base_d;
      addr_q     <= addr_d;
      sel_q      <= sel_d;
      dly_q      <= dly_d;
      out_q      <= out_d;
      pix_q      <= pix_d;
    end
  end

  assign bus.gpu_address = addr_q;
  assign bus.gpu_sel     = sel_q;
  assign bus.vga_r       = pix_q;
  assign bus.vga_g       = pix_q;
  assign bus.vga_b       = pix_q;
  assign bus.vga_hsync   = out_q.hsync_n;
  assign bus.vga_vsync   = out_q.vsync_n;
  assign bus.vga_blank_n = out_q.visible;
  assign bus.frame_start = out_q.frame_start;

endmodule
